// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Raises a maskable interrupt when the count expires.
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h00007f00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_CNT  = 2'b10,
        S_INT  = 2'b11
    } state_t;

    state_t      state_q;
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_flag_q;

    logic [31:0] byte_addr_s;
    logic        wr_ctrl_s;
    logic        wr_preset_s;
    logic        auto_reload_s;

    assign byte_addr_s   = {addr, 2'b00};
    assign auto_reload_s = (ctrl_q[2:1] == 2'b01);

    // Write decode: only CTRL and PRESET are writable; COUNT is read-only.
    always_comb begin
        wr_ctrl_s   = 1'b0;
        wr_preset_s = 1'b0;
        if (we && (byte_addr_s == BASE_ADDR)) begin
            wr_ctrl_s = 1'b1;
        end else if (we && (byte_addr_s == (BASE_ADDR + 32'd4))) begin
            wr_preset_s = 1'b1;
        end else begin
            wr_ctrl_s   = 1'b0;
            wr_preset_s = 1'b0;
        end
    end

    // Counter FSM and register file; software CTRL writes override FSM updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctrl_q[0]) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    count_q <= preset_q;
                    state_q <= S_CNT;
                end
                S_CNT: begin
                    if (!ctrl_q[0]) begin
                        state_q <= S_IDLE;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        // A preset of zero lands here too, so it expires like one.
                        count_q    <= 32'd0;
                        irq_flag_q <= 1'b1;
                        state_q    <= S_INT;
                    end
                end
                S_INT: begin
                    state_q <= S_IDLE;
                    if (auto_reload_s) begin
                        irq_flag_q <= 1'b0;
                    end else begin
                        ctrl_q[0] <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (wr_ctrl_s) begin
                ctrl_q     <= din[3:0];
                irq_flag_q <= 1'b0;
            end
            if (wr_preset_s) begin
                preset_q <= din;
            end
        end
    end

    // Read mux, independent of the write strobe.
    always_comb begin
        dout = 32'd0;
        if (byte_addr_s == BASE_ADDR) begin
            dout = {28'd0, ctrl_q};
        end else if (byte_addr_s == (BASE_ADDR + 32'd4)) begin
            dout = preset_q;
        end else if (byte_addr_s == (BASE_ADDR + 32'd8)) begin
            dout = count_q;
        end else begin
            dout = 32'd0;
        end
    end

    assign irq = ctrl_q[3] & irq_flag_q;

endmodule
